// File: rtl/risc16_loader_pkg.sv
// Shared types and constants for the risc16f boot/program loader.
// Holds the loader state encoding, the default frame sync byte and the
// instruction-memory address step per 16-bit word.
package risc16_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [3:0] {
    IDLE,
    LEN_H,
    LEN_L,
    DATA_H,
    DATA_L,
    CHK_H,
    CHK_L,
    RUN,
    ERR
  } ldr_state_t;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [WORD_W-1:0] ADDR_STEP     = 16'd2;

endpackage

// File: rtl/risc16_loader_byte_asm.sv
// Pairs a latched high byte with the incoming low byte to form a 16-bit
// word and, with RISC16_LOADER_CHKSUM_EN defined, keeps a modulo-2^16 sum
// of the data words of the current frame.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   hi_en       latch rx_data as the high byte
//   rx_data     host byte
//   word_c      {latched high byte, rx_data} (combinational)
//   clr         (checksum build) clear the running sum at frame start
//   lo_en       (checksum build) add word_c to the running sum
//   sum         (checksum build) running sum of data words
module risc16_loader_byte_asm
  import risc16_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
`ifdef RISC16_LOADER_CHKSUM_EN
  input  logic              clr,
  input  logic              lo_en,
  output logic [WORD_W-1:0] sum,
`endif
  input  logic              hi_en,
  input  logic [BYTE_W-1:0] rx_data,
  output logic [WORD_W-1:0] word_c
);

  logic [BYTE_W-1:0] hi;

  // High byte holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
    end else if (hi_en) begin
      hi <= rx_data;
    end
  end

  assign word_c = {hi, rx_data};

`ifdef RISC16_LOADER_CHKSUM_EN
  // Running sum of data words; wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= '0;
    end else if (lo_en) begin
      sum <= sum + word_c;
    end
  end
`endif

endmodule

// File: rtl/risc16_loader.sv
// Boot/program loader and run controller for the risc16f core.
// Accepts a framed byte stream (sync, length hi/lo, data words hi/lo and,
// when RISC16_LOADER_CHKSUM_EN is defined, a 2-byte checksum), writes the
// words to instruction memory and holds the core in reset until the image
// is complete. A sync byte while running restarts loading.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   rx_data      host byte
//   rx_valid     host byte valid
//   rx_ready     byte accepted when rx_valid && rx_ready
//   mem_addr     imem byte address (even)
//   mem_wdata    imem write word
//   mem_we       imem write strobe, one cycle per word
//   cpu_rst      core reset, low only in RUN
//   busy         frame in progress
//   err          sticky frame error, cleared by the next sync byte
//   word_cnt     words written in the current/last frame
//   run_cnt      cycles since core release, saturating
// Optional feature macro: RISC16_LOADER_CHKSUM_EN
module risc16_loader
  import risc16_loader_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter logic [WORD_W-1:0] LOAD_BASE = 16'h0000,
  parameter logic [WORD_W-1:0] MAX_WORDS = 16'd32768
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_rst,
  output logic              busy,
  output logic              err,
  output logic [WORD_W-1:0] word_cnt,
  output logic [WORD_W-1:0] run_cnt
);

  ldr_state_t        state;
  ldr_state_t        nxt_state;
  logic [WORD_W-1:0] len;
  logic [WORD_W-1:0] asm_word_c;
  logic              accept;
  logic              frame_start;
  logic              hi_en;
  logic              wr_fire;
  logic              last_word;

`ifdef RISC16_LOADER_CHKSUM_EN
  logic [WORD_W-1:0] chk_sum;
  localparam ldr_state_t POST_DATA = CHK_H;
`else
  localparam ldr_state_t POST_DATA = RUN;
`endif

  assign accept      = rx_valid && rx_ready;
  // Sync is only a frame marker outside a frame; inside it is plain data
  assign frame_start = accept && (rx_data == SYNC_BYTE) && (state inside {IDLE, RUN, ERR});
  assign wr_fire     = accept && (state == DATA_L);
  assign last_word   = (word_cnt + 16'd1) == len;

`ifdef RISC16_LOADER_CHKSUM_EN
  assign hi_en = accept && (state inside {LEN_H, DATA_H, CHK_H});
`else
  assign hi_en = accept && (state inside {LEN_H, DATA_H});
`endif

  risc16_loader_byte_asm u_byte_asm (
    .clk     (clk),
    .rst     (rst),
`ifdef RISC16_LOADER_CHKSUM_EN
    .clr     (frame_start),
    .lo_en   (wr_fire),
    .sum     (chk_sum),
`endif
    .hi_en   (hi_en),
    .rx_data (rx_data),
    .word_c  (asm_word_c)
  );

  // Next-state decode
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE, RUN, ERR: if (frame_start) nxt_state = LEN_H;
      LEN_H:          if (accept) nxt_state = LEN_L;
      LEN_L: begin
        if (accept) begin
          if (asm_word_c > MAX_WORDS) begin
            nxt_state = ERR;
          end else if (asm_word_c == '0) begin
            nxt_state = POST_DATA;
          end else begin
            nxt_state = DATA_H;
          end
        end
      end
      DATA_H:         if (accept) nxt_state = DATA_L;
      // Stay in DATA_L through the write cycle so release follows the write
      DATA_L:         if (mem_we) nxt_state = last_word ? POST_DATA : DATA_H;
`ifdef RISC16_LOADER_CHKSUM_EN
      CHK_H:          if (accept) nxt_state = CHK_L;
      CHK_L:          if (accept) nxt_state = (asm_word_c == chk_sum) ? RUN : ERR;
`endif
      default:        nxt_state = IDLE;
    endcase
  end

  // State, counters, memory strobe and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= LOAD_BASE;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      busy      <= 1'b0;
      err       <= 1'b0;
      word_cnt  <= '0;
      run_cnt   <= '0;
    end else begin
      state    <= nxt_state;
      cpu_rst  <= (nxt_state != RUN);
      busy     <= nxt_state inside {LEN_H, LEN_L, DATA_H, DATA_L, CHK_H, CHK_L};
      mem_we   <= wr_fire;
      // One-cycle bubble covering the write cycle
      rx_ready <= !wr_fire;

      if (wr_fire) begin
        mem_wdata <= asm_word_c;
      end
      if (accept && (state == LEN_L)) begin
        len <= asm_word_c;
      end

      if (frame_start) begin
        mem_addr <= LOAD_BASE;
        word_cnt <= '0;
        err      <= 1'b0;
        run_cnt  <= '0;
      end else begin
        if (mem_we) begin
          mem_addr <= mem_addr + ADDR_STEP;
          word_cnt <= word_cnt + 16'd1;
        end
        if (nxt_state == ERR) begin
          err <= 1'b1;
        end
        if (nxt_state == RUN) begin
          if (state != RUN) begin
            run_cnt <= '0;
          end else if (run_cnt != 16'hFFFF) begin
            run_cnt <= run_cnt + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_risc16_loader.sv
// Self-checking bench for risc16_loader: table of whole frames with expected
// writes and final status, plus hand sequences for release timing, reload
// while running and reset in the middle of a frame.
module tb_risc16_loader;

  localparam logic [15:0] LOAD_BASE = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        cpu_rst;
  logic        busy;
  logic        err;
  logic [15:0] word_cnt;
  logic [15:0] run_cnt;

  risc16_loader #(
    .SYNC_BYTE (8'hA5),
    .LOAD_BASE (LOAD_BASE),
    .MAX_WORDS (16'd32768)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .err       (err),
    .word_cnt  (word_cnt),
    .run_cnt   (run_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] wq[$];
  int n_writes   = 0;
  int n_bubbles  = 0;
  int bubble_bad = 0;
  int odd_addr   = 0;

  // Write capture and rx_ready bubble tracking, sampled just after each edge
  always @(posedge clk) begin
    #1;
    if (mem_we) begin
      wq.push_back({mem_addr, mem_wdata});
      n_writes++;
      if (mem_addr[0]) odd_addr++;
    end
    if (!rst) begin
      if (rx_ready == mem_we) bubble_bad++;
      if (!rx_ready) n_bubbles++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Present a byte from a falling edge and return after the accepting edge
  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: rx_ready stuck 0 for byte %02h", b);
    end
    @(posedge clk);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  typedef struct {
    logic [79:0] bytes;     // n bytes, right-aligned, first byte most significant
    int          n;
    int          nw;
    logic [15:0] w0;
    logic [15:0] w1;
    logic        exp_cpu_rst;
    logic        exp_err;
    logic        exp_busy;
    logic [15:0] exp_wc;
  } vec_t;

  vec_t vecs[6];
  int   nvec;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef RISC16_LOADER_CHKSUM_EN
    vecs[0] = '{80'hA5_00_02_12_34_AB_CD_BE_01, 9, 2, 16'h1234, 16'hABCD, 1'b0, 1'b0, 1'b0, 16'd2};
    vecs[1] = '{80'hA5_00_00_00_00,             5, 0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[2] = '{80'hA5_80_01,                   3, 0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[3] = '{80'h00_FF_A5_00_01_BE_EF_BE_EF, 9, 1, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[4] = '{80'hA5_00_01_FF_FF_FF_FF,       7, 1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[5] = '{80'hA5_00_02_12_34_AB_CD_BE_02, 9, 2, 16'h1234, 16'hABCD, 1'b1, 1'b1, 1'b0, 16'd2};
    nvec = 6;
`else
    vecs[0] = '{80'hA5_00_02_12_34_AB_CD,       7, 2, 16'h1234, 16'hABCD, 1'b0, 1'b0, 1'b0, 16'd2};
    vecs[1] = '{80'hA5_00_00,                   3, 0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[2] = '{80'hA5_80_01,                   3, 0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[3] = '{80'h00_FF_A5_00_01_BE_EF,       7, 1, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[4] = '{80'hA5_00_01_FF_FF,             5, 1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd1};
    nvec = 5;
`endif

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst cpu_rst",   32'(cpu_rst),   32'd1);
    chk("rst rx_ready",  32'(rx_ready),  32'd0);
    chk("rst mem_we",    32'(mem_we),    32'd0);
    chk("rst busy",      32'(busy),      32'd0);
    chk("rst err",       32'(err),       32'd0);
    chk("rst mem_addr",  32'(mem_addr),  32'(LOAD_BASE));
    chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst word_cnt",  32'(word_cnt),  32'd0);
    chk("rst run_cnt",   32'(run_cnt),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst rx_ready", 32'(rx_ready), 32'd1);
    chk("post-rst cpu_rst",  32'(cpu_rst),  32'd1);

    // Whole-frame table, rx_valid held high for each frame
    for (int i = 0; i < nvec; i++) begin
      wq.delete();
      for (int k = 0; k < vecs[i].n; k++) begin
        send(vecs[i].bytes[8*(vecs[i].n-1-k) +: 8]);
      end
      drop_valid();
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d write count", i), 32'(wq.size()), 32'(vecs[i].nw));
      if (wq.size() > 0 && vecs[i].nw > 0)
        chk($sformatf("v%0d write0", i), wq[0], {LOAD_BASE, vecs[i].w0});
      if (wq.size() > 1 && vecs[i].nw > 1)
        chk($sformatf("v%0d write1", i), wq[1], {16'(LOAD_BASE + 16'd2), vecs[i].w1});
      chk($sformatf("v%0d cpu_rst", i),  32'(cpu_rst),  32'(vecs[i].exp_cpu_rst));
      chk($sformatf("v%0d err", i),      32'(err),      32'(vecs[i].exp_err));
      chk($sformatf("v%0d busy", i),     32'(busy),     32'(vecs[i].exp_busy));
      chk($sformatf("v%0d word_cnt", i), 32'(word_cnt), 32'(vecs[i].exp_wc));
    end

    // Release timing: cpu_rst falls the cycle after the last write
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
    drop_valid();
    chk("rel write mem_we",   32'(mem_we),    32'd1);
    chk("rel write addr",     32'(mem_addr),  32'(LOAD_BASE + 16'd2));
    chk("rel write data",     32'(mem_wdata), 32'hABCD);
    chk("rel write rx_ready", 32'(rx_ready),  32'd0);
    chk("rel write cpu_rst",  32'(cpu_rst),   32'd1);
`ifdef RISC16_LOADER_CHKSUM_EN
    @(negedge clk);
    chk("rel chk_h cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rel chk_h busy",    32'(busy),    32'd1);
    send(8'hBE); send(8'h01);
    drop_valid();
`else
    @(negedge clk);
`endif
    chk("rel cpu_rst",  32'(cpu_rst),  32'd0);
    chk("rel run_cnt0", 32'(run_cnt),  32'd0);
    chk("rel word_cnt", 32'(word_cnt), 32'd2);
    repeat (3) @(negedge clk);
    chk("run_cnt 3", 32'(run_cnt), 32'd3);

    // Non-sync byte in RUN is ignored; sync restarts loading
    send(8'h55);
    drop_valid();
    chk("run 55 cpu_rst", 32'(cpu_rst), 32'd0);
    chk("run 55 busy",    32'(busy),    32'd0);
    send(8'hA5);
    drop_valid();
    chk("reload cpu_rst",  32'(cpu_rst),  32'd1);
    chk("reload busy",     32'(busy),     32'd1);
    chk("reload run_cnt",  32'(run_cnt),  32'd0);
    chk("reload word_cnt", 32'(word_cnt), 32'd0);
    send(8'h00); send(8'h01); send(8'hBE); send(8'hEF);
    drop_valid();
    chk("reload mem_we", 32'(mem_we),    32'd1);
    chk("reload addr",   32'(mem_addr),  32'(LOAD_BASE));
    chk("reload data",   32'(mem_wdata), 32'hBEEF);
`ifdef RISC16_LOADER_CHKSUM_EN
    send(8'hBE); send(8'hEF);
    drop_valid();
`else
    @(negedge clk);
`endif
    chk("reload run cpu_rst", 32'(cpu_rst), 32'd0);

    // Max length accepted, then reset mid-frame aborts further writes
    wq.delete();
    send(8'hA5); send(8'h80); send(8'h00);
    drop_valid();
    chk("maxlen busy",    32'(busy),    32'd1);
    chk("maxlen err",     32'(err),     32'd0);
    chk("maxlen cpu_rst", 32'(cpu_rst), 32'd1);
    send(8'h12); send(8'h34);
    drop_valid();
    chk("maxlen mem_we", 32'(mem_we), 32'd1);
    send(8'h56);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(8'h78);
    drop_valid();
    repeat (2) @(negedge clk);
    chk("abort write count", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) chk("abort write0", wq[0], {LOAD_BASE, 16'h1234});
    chk("abort busy",     32'(busy),     32'd0);
    chk("abort cpu_rst",  32'(cpu_rst),  32'd1);
    chk("abort mem_addr", 32'(mem_addr), 32'(LOAD_BASE));
    chk("abort word_cnt", 32'(word_cnt), 32'd0);
    chk("abort err",      32'(err),      32'd0);

    // Backpressure bookkeeping across the whole run
    chk("bubble only on write", 32'(bubble_bad), 32'd0);
    chk("bubbles per write",    32'(n_bubbles),  32'(n_writes));
    chk("odd write address",    32'(odd_addr),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/risc16_loader.md
Name: risc16_loader

Overview:
- Boot/program loader and run controller for the risc16f core.
- Receives a byte-stream program image from a host link, writes it as 16-bit words into instruction memory, and holds the core in reset while loading.
- Releases the core into RUN once the image is complete and valid. A new sync byte while running re-enters loading and re-asserts core reset.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- LOAD_BASE, 16'h0000, byte address of the first loaded word.
- MAX_WORDS, 16'd32768, largest accepted frame length in words.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  host byte
- rx_valid  in  1  host byte valid
- rx_ready  out  1  loader accepts byte; a transfer occurs when rx_valid&&rx_ready
- mem_addr  out  16  imem byte address (even)
- mem_wdata  out  16  imem write word
- mem_we  out  1  imem write strobe, one cycle per word
- cpu_rst  out  1  reset to risc16f (active-high)
- busy  out  1  frame in progress (LEN_H..CHK_L)
- err  out  1  sticky frame error, cleared on next sync byte
- word_cnt  out  16  words written in current/last frame
- run_cnt  out  16  cycles since core release, saturating at 16'hFFFF

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: state IDLE, rx_ready=0, mem_we=0, mem_addr=LOAD_BASE, mem_wdata=0, cpu_rst=1, busy=0, err=0, word_cnt=0, run_cnt=0. rx_ready goes to 1 the cycle after rst deasserts.
- States: IDLE, LEN_H, LEN_L, DATA_H, DATA_L, CHK_H, CHK_L, RUN, ERR.
- IDLE: accepts and discards bytes until rx_data==SYNC_BYTE, then goes to LEN_H. The sync byte clears err, word_cnt and the checksum, and sets mem_addr=LOAD_BASE.
- LEN_H / LEN_L: latch length high byte, then low byte.
  - After LEN_L: if len>MAX_WORDS, go to ERR.
  - If len==0, go to RUN (CHK_H when the macro is enabled).
  - Otherwise go to DATA_H.
- DATA_H: latch high byte. DATA_L: on accept, the next cycle drives mem_we=1, mem_wdata={hi,lo}, mem_addr=current address.
- Write bookkeeping: after the mem_we cycle, address +=2, wrapping 0xFFFE->0x0000 with no error; word_cnt +=1.
- Backpressure: rx_ready=0 during the single mem_we cycle and 1 in all other non-reset cycles. Latency is 1 cycle from low-byte accept to write.
- Last word: after the write of word len, go to RUN (or CHK_H when the macro is enabled).
- RUN: cpu_rst=0 from the first RUN cycle. run_cnt starts at 0 and increments each cycle, saturating. Non-sync bytes are accepted and ignored.
  - A sync byte asserts cpu_rst=1 the next cycle, clears run_cnt and goes to LEN_H.
- ERR: cpu_rst=1, err=1. Only a sync byte leaves ERR, going to LEN_H.
- cpu_rst=1 in every state except RUN. rst mid-frame aborts with no further writes and returns to IDLE.
- busy=1 in LEN_H..CHK_L, else 0.

Optional Feature:
- Macro: RISC16_LOADER_CHKSUM_EN.
- Enabled:
  - The loader keeps a 16-bit modulo-2^16 sum of the data words.
  - After the data words it expects 2 checksum bytes, high byte first (CHK_H, CHK_L).
  - On match, go to RUN. On mismatch, go to ERR with no release.
- Disabled: the CHK states and checksum logic are absent, and DATA_L/LEN_L go straight to RUN.

Decomposition:
- Package risc16_loader_pkg holds: a state enum typedef (ldr_state_t), SYNC_BYTE default, and the address step constant (2).
- One natural sub-module, risc16_loader_byte_asm: pairs high/low bytes into a word and accumulates the checksum.
- The FSM, counters and memory strobe stay in the top.

Test Plan:
1. Reset:
   - Stimulus: rst high 3 cycles.
   - Required: cpu_rst=1, rx_ready=0, mem_we=0, state IDLE. Cycle after rst deasserts, rx_ready=1.
2. Basic load:
   - Stimulus: A5 00 02 12 34 AB CD.
   - Required: mem_we pulses with (0x0000,0x1234) then (0x0002,0xABCD). word_cnt=2. cpu_rst falls the cycle after the second write, and run_cnt counts up from 0.
3. Zero/oversize length:
   - Stimulus: A5 00 00.
   - Required: no mem_we, RUN entered.
   - Stimulus: A5 80 01 (len 32769).
   - Required: ERR, err=1, cpu_rst=1.
4. Reload while running:
   - Stimulus: in RUN, send 55 (ignored, cpu_rst stays 0), then A5.
   - Required: cpu_rst=1 the next cycle, busy=1, run_cnt=0.
   - Stimulus: a new 1-word frame 00 01 BE EF.
   - Required: write to LOAD_BASE, then RUN.
5. Backpressure/garbage:
   - Stimulus: rx_valid held high continuously; bytes 00 FF precede A5.
   - Required: leading bytes discarded; exactly one rx_ready=0 bubble per word write; no byte lost.
6. Checksum (RISC16_LOADER_CHKSUM_EN):
   - Stimulus: A5 00 02 12 34 AB CD BE 01.
   - Required: RUN.
   - Stimulus: same frame with checksum BE 02.
   - Required: ERR; both words still written; cpu_rst stays 1.
